// File: rtl/decode_exec_pc_pkg.sv
// Shared constants for the single-cycle decode/execute/PC slice:
// ALU opcodes, MIPS opcode/funct encodings and the reset PC.
package decode_exec_pc_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

endpackage

// File: rtl/decode_exec_pc_alu.sv
// Combinational ALU: shifts, unsigned MUL/DIV with a secondary result,
// arithmetic, logic and set-less-than operations.
module alu
    import decode_exec_pc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic [31:0] result2
);

    logic [63:0] product;

    assign product = 64'(a) * 64'(b);

    always_comb begin
        result  = '0;
        result2 = '0;
        case (op)
            ALU_SLL:  result = b << shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_MUL: begin
                result  = product[31:0];
                result2 = product[63:32];
            end
            // Divide-by-zero returns all ones and passes the dividend through.
            ALU_DIV: begin
                if (b == '0) begin
                    result  = '1;
                    result2 = a;
                end else begin
                    result  = a / b;
                    result2 = a % b;
                end
            end
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/decode_exec_pc_ctrl_decode.sv
// Instruction decoder: maps MIPS opcode/funct to ALU opcode and datapath
// strobes. Unknown encodings decode to a NOP.
module ctrl_decode
    import decode_exec_pc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write,
    output logic       syscall,
    output logic       signed_ext,
    output logic       reg_dst,
    output logic       beq,
    output logic       bne,
    output logic       jr,
    output logic       jmp,
    output logic       jal,
    output logic       shift,
    output logic       lb,
    output logic       bgtz
);

    always_comb begin
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        syscall    = 1'b0;
        signed_ext = 1'b0;
        reg_dst    = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        jr         = 1'b0;
        jmp        = 1'b0;
        jal        = 1'b0;
        shift      = 1'b0;
        lb         = 1'b0;
        bgtz       = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  begin alu_op = ALU_SLL;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SRL:  begin alu_op = ALU_SRL;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SRA:  begin alu_op = ALU_SRA;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA;  reg_write = 1'b1; reg_dst = 1'b1; shift = 1'b1; end
                    FN_ADD,
                    FN_ADDU: begin alu_op = ALU_ADD;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SUB:  begin alu_op = ALU_SUB;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_AND:  begin alu_op = ALU_AND;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_OR:   begin alu_op = ALU_OR;   reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_NOR:  begin alu_op = ALU_NOR;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SLT:  begin alu_op = ALU_SLT;  reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_SLTU: begin alu_op = ALU_SLTU; reg_write = 1'b1; reg_dst = 1'b1; end
                    FN_JR:      begin jr = 1'b1; jmp = 1'b1; end
                    FN_SYSCALL: syscall = 1'b1;
                    default: ;
                endcase
            end
            OP_J:    jmp = 1'b1;
            OP_JAL:  begin jmp = 1'b1; jal = 1'b1; reg_write = 1'b1; end
            OP_BEQ:  begin beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:  begin bne = 1'b1; alu_op = ALU_SUB; end
            OP_BGTZ: begin bgtz = 1'b1; alu_op = ALU_SLT; end
            OP_ADDI,
            OP_ADDIU: begin alu_op = ALU_ADD; alu_src = 1'b1; signed_ext = 1'b1; reg_write = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT; alu_src = 1'b1; signed_ext = 1'b1; reg_write = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND; alu_src = 1'b1; reg_write = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;  alu_src = 1'b1; reg_write = 1'b1; end
            OP_LB, OP_LW: begin
                alu_op     = ALU_ADD;
                alu_src    = 1'b1;
                signed_ext = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                lb         = (op == OP_LB);
            end
            OP_SW: begin alu_op = ALU_ADD; alu_src = 1'b1; signed_ext = 1'b1; mem_write = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_exec_pc.sv
// Single-cycle core slice: PC register, decoder, ALU and next-PC selection.
// Only pc is registered; everything else follows ins/rd1/rd2/pc combinationally.
module decode_exec_pc
    import decode_exec_pc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic [31:0] ins,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  alu_op,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        syscall,
    output logic        signed_ext,
    output logic        reg_dst,
    output logic        beq,
    output logic        bne,
    output logic        jr,
    output logic        jmp,
    output logic        jal,
    output logic        shift,
    output logic        lb,
    output logic        bgtz,
    output logic [31:0] result,
    output logic [31:0] result2,
    output logic        equ,
    output logic        branch_taken
);

    logic [31:0] imm_ext;
    logic [31:0] imm_sext;
    logic [31:0] b_operand;
    logic [4:0]  shamt;
    logic [31:0] next_pc;

    ctrl_decode u_ctrl_decode (
        .op         (ins[31:26]),
        .funct      (ins[5:0]),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .syscall    (syscall),
        .signed_ext (signed_ext),
        .reg_dst    (reg_dst),
        .beq        (beq),
        .bne        (bne),
        .jr         (jr),
        .jmp        (jmp),
        .jal        (jal),
        .shift      (shift),
        .lb         (lb),
        .bgtz       (bgtz)
    );

    assign imm_sext  = {{16{ins[15]}}, ins[15:0]};
    assign imm_ext   = signed_ext ? imm_sext : {16'b0, ins[15:0]};
    assign b_operand = alu_src ? imm_ext : rd2;
    assign shamt     = shift ? rd1[4:0] : ins[10:6];

    alu u_alu (
        .op      (alu_op),
        .a       (rd1),
        .b       (b_operand),
        .shamt   (shamt),
        .result  (result),
        .result2 (result2)
    );

    assign pc_plus4 = pc + 32'd4;
    assign equ      = (rd1 == b_operand);
    // bgtz compares rs against rt = $0: not negative (SLT == 0) and not equal.
    assign branch_taken = (beq & equ) | (bne & ~equ) | (bgtz & (result == '0) & ~equ);

    always_comb begin
        if (jal || (jmp && !jr))
            next_pc = {pc_plus4[31:28], ins[25:0], 2'b00};
        else if (jr)
            next_pc = rd1;
        else if (branch_taken)
            next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
        else
            next_pc = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (pc_en)
            pc <= next_pc;
    end

endmodule

// File: tb/tb_decode_exec_pc.sv
// Self-checking bench for decode_exec_pc; expectations are queued when
// stimulus is applied and popped when the DUT output is sampled.
module tb_decode_exec_pc;
    import decode_exec_pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pc_en;
    logic [31:0] ins, rd1, rd2;
    logic [31:0] pc, pc_plus4, result, result2;
    logic [3:0]  alu_op;
    logic        mem_to_reg, mem_write, alu_src, reg_write, syscall, signed_ext, reg_dst;
    logic        beq, bne, jr, jmp, jal, shift, lb, bgtz, equ, branch_taken;
    logic [14:0] strobes;

    logic [3:0]  aop;
    logic [31:0] aa, ab, ares, ares2;
    logic [4:0]  ash;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    localparam logic [14:0] S_MEM_TO_REG = 15'h4000, S_MEM_WRITE = 15'h2000, S_ALU_SRC = 15'h1000,
                            S_REG_WRITE = 15'h0800, S_SYSCALL = 15'h0400, S_SIGNED_EXT = 15'h0200,
                            S_REG_DST = 15'h0100, S_BEQ = 15'h0080, S_BNE = 15'h0040, S_JR = 15'h0020,
                            S_JMP = 15'h0010, S_JAL = 15'h0008, S_SHIFT = 15'h0004, S_LB = 15'h0002,
                            S_BGTZ = 15'h0001;

    assign strobes = {mem_to_reg, mem_write, alu_src, reg_write, syscall, signed_ext, reg_dst,
                      beq, bne, jr, jmp, jal, shift, lb, bgtz};

    always #5 clk = ~clk;

    decode_exec_pc dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .ins(ins), .rd1(rd1), .rd2(rd2),
        .pc(pc), .pc_plus4(pc_plus4), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .syscall(syscall), .signed_ext(signed_ext), .reg_dst(reg_dst), .beq(beq), .bne(bne),
        .jr(jr), .jmp(jmp), .jal(jal), .shift(shift), .lb(lb), .bgtz(bgtz),
        .result(result), .result2(result2), .equ(equ), .branch_taken(branch_taken)
    );

    alu u_alu_direct (.op(aop), .a(aa), .b(ab), .shamt(ash), .result(ares), .result2(ares2));

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ins = i; rd1 = a; rd2 = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [25:0] target);
        apply({OP_J, target}, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_en = 1'b1; ins = 32'h0; rd1 = '0; rd2 = '0;
        exp_q.push_back(32'h0);
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, exp_v); end
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'(4 * i));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (pc !== exp_v) begin fails++; $display("FAIL pc_step%0d: got %h expected %h", i, pc, exp_v); end
        end
        @(negedge clk); pc_en = 1'b0;
        exp_q.push_back(32'd12);
        step(); step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL pc_hold: got %h expected %h", pc, exp_v); end
        @(negedge clk); pc_en = 1'b1;
    endtask

    task automatic test_alu();
        apply({OP_ADDI, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd99);
        exp_q.push_back(32'd4);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL addi_result: got %h expected %h", result, exp_v); end
        checks++;
        if (strobes !== (S_ALU_SRC | S_REG_WRITE | S_SIGNED_EXT)) begin
            fails++; $display("FAIL addi_strobes: got %h expected %h", strobes, S_ALU_SRC | S_REG_WRITE | S_SIGNED_EXT);
        end
        apply({OP_SLTI, 5'd1, 5'd2, 16'h0001}, 32'hFFFF_FFFE, 32'd0);
        exp_q.push_back(32'd1);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL slti_result: got %h expected %h", result, exp_v); end
        apply({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_SLTU}, 32'hFFFF_FFFE, 32'd1);
        exp_q.push_back(32'd0);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL sltu_result: got %h expected %h", result, exp_v); end
        apply({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_SRAV}, 32'd4, 32'h8000_0000);
        exp_q.push_back(32'hF800_0000);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL srav_result: got %h expected %h", result, exp_v); end
        apply({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd4, FN_SLL}, 32'd31, 32'd3);
        exp_q.push_back(32'd48);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL sll_result: got %h expected %h", result, exp_v); end
        apply({OP_ANDI, 5'd1, 5'd2, 16'hFFFF}, 32'hFFFF_FFFF, 32'd0);
        exp_q.push_back(32'h0000_FFFF);
        exp_v = exp_q.pop_front(); checks++;
        if (result !== exp_v) begin fails++; $display("FAIL andi_zext: got %h expected %h", result, exp_v); end
    endtask

    task automatic test_mul_div();
        logic [3:0]  ops[4] = '{ALU_MUL, ALU_DIV, ALU_DIV, 4'd13};
        logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'd7, 32'd9, 32'd7};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd0, 32'd2};
        logic [31:0] r1[4]  = '{32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] r2[4]  = '{32'd1, 32'd1, 32'd9, 32'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aop = ops[i]; aa = as[i]; ab = bs[i]; ash = 5'd0;
            exp_q.push_back(r1[i]);
            exp_q.push_back(r2[i]);
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (ares !== exp_v) begin fails++; $display("FAIL muldiv%0d_result: got %h expected %h", i, ares, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (ares2 !== exp_v) begin fails++; $display("FAIL muldiv%0d_result2: got %h expected %h", i, ares2, exp_v); end
        end
    endtask

    task automatic test_decode();
        logic [31:0] dins[3] = '{{OP_LB, 26'h0}, {OP_SW, 26'h0}, {OP_RTYPE, 20'h0, FN_SYSCALL}};
        logic [14:0] dexp[3] = '{S_MEM_TO_REG | S_ALU_SRC | S_REG_WRITE | S_SIGNED_EXT | S_LB,
                                 S_MEM_WRITE | S_ALU_SRC | S_SIGNED_EXT, S_SYSCALL};
        for (int i = 0; i < 3; i++) begin
            apply(dins[i], 32'h0, 32'h0);
            exp_q.push_back(32'(dexp[i]));
            exp_v = exp_q.pop_front(); checks++;
            if (strobes !== exp_v[14:0]) begin
                fails++; $display("FAIL decode%0d_strobes: got %h expected %h", i, strobes, exp_v[14:0]);
            end
        end
        goto(26'h0C0);
        apply(32'hFC00_0000, 32'h0, 32'h0);
        exp_q.push_back({17'h0, 15'h0});
        exp_q.push_back({28'h0, ALU_ADD});
        exp_q.push_back(32'h304);
        exp_v = exp_q.pop_front(); checks++;
        if (strobes !== exp_v[14:0]) begin fails++; $display("FAIL nop_strobes: got %h expected %h", strobes, exp_v[14:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (alu_op !== exp_v[3:0]) begin fails++; $display("FAIL nop_alu_op: got %h expected %h", alu_op, exp_v[3:0]); end
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL nop_pc: got %h expected %h", pc, exp_v); end
    endtask

    task automatic test_branch();
        logic [5:0]  bop[5]  = '{OP_BEQ, OP_BNE, OP_BGTZ, OP_BGTZ, OP_BGTZ};
        logic [31:0] b1[5]   = '{32'd7, 32'd7, 32'd5, 32'd0, 32'hFFFF_FFF0};
        logic [31:0] b2[5]   = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd0};
        logic [31:0] bpc[5]  = '{32'h110, 32'h104, 32'h110, 32'h104, 32'h104};
        for (int i = 0; i < 5; i++) begin
            goto(26'h40);
            exp_q.push_back(32'h100);
            exp_v = exp_q.pop_front(); checks++;
            if (pc !== exp_v) begin fails++; $display("FAIL branch%0d_start: got %h expected %h", i, pc, exp_v); end
            apply({bop[i], 5'd1, (bop[i] == OP_BGTZ) ? 5'd0 : 5'd2, 16'd3}, b1[i], b2[i]);
            exp_q.push_back({31'b0, bpc[i] == 32'h110});
            exp_q.push_back(bpc[i]);
            exp_v = exp_q.pop_front(); checks++;
            if (branch_taken !== exp_v[0]) begin
                fails++; $display("FAIL branch%0d_taken: got %b expected %b", i, branch_taken, exp_v[0]);
            end
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (pc !== exp_v) begin fails++; $display("FAIL branch%0d_pc: got %h expected %h", i, pc, exp_v); end
        end
    endtask

    task automatic test_jump();
        goto(26'h10_0000);
        apply({OP_JAL, 26'h10}, 32'h0, 32'h0);
        exp_q.push_back(32'h0040_0004);
        exp_q.push_back(32'(S_JAL | S_JMP | S_REG_WRITE));
        exp_q.push_back(32'h40);
        exp_v = exp_q.pop_front(); checks++;
        if (pc_plus4 !== exp_v) begin fails++; $display("FAIL jal_link: got %h expected %h", pc_plus4, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (strobes !== exp_v[14:0]) begin fails++; $display("FAIL jal_strobes: got %h expected %h", strobes, exp_v[14:0]); end
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL jal_pc: got %h expected %h", pc, exp_v); end
        apply({OP_RTYPE, 5'd31, 15'h0, FN_JR}, 32'h200, 32'h0);
        exp_q.push_back(32'(S_JR | S_JMP));
        exp_q.push_back(32'h200);
        exp_v = exp_q.pop_front(); checks++;
        if (strobes !== exp_v[14:0]) begin fails++; $display("FAIL jr_strobes: got %h expected %h", strobes, exp_v[14:0]); end
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL jr_pc: got %h expected %h", pc, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fn[6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
        logic [31:0] a, b, e;
        int k;
        goto(26'h400);
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 5);
            a = $urandom; b = $urandom;
            if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'd1; k = 0; end
            case (k)
                0: e = a + b;
                1: e = a - b;
                2: e = a & b;
                3: e = a | b;
                4: e = ~(a | b);
                default: e = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            endcase
            apply({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, fn[k]}, a, b);
            exp_q.push_back(e);
            exp_q.push_back(32'h1000 + 32'(4 * i));
            exp_v = exp_q.pop_front(); checks++;
            if (result !== exp_v) begin fails++; $display("FAIL b2b%0d_result: got %h expected %h", i, result, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (pc !== exp_v) begin fails++; $display("FAIL b2b%0d_pc: got %h expected %h", i, pc, exp_v); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        goto(26'h200);
        apply({OP_JAL, 26'h3000}, 32'h0, 32'h0);
        rst = 1'b1;
        exp_q.push_back(RESET_PC);
        exp_q.push_back(RESET_PC + 32'd4);
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL midrst_pc: got %h expected %h", pc, exp_v); end
        apply(32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL midrst_fetch: got %h expected %h", pc, exp_v); end
        goto(26'h200);
        @(negedge clk); pc_en = 1'b0; rst = 1'b1;
        exp_q.push_back(RESET_PC);
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (pc !== exp_v) begin fails++; $display("FAIL rst_over_en: got %h expected %h", pc, exp_v); end
        @(negedge clk); rst = 1'b0; pc_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; pc_en = 1'b0; ins = '0; rd1 = '0; rd2 = '0;
        aop = '0; aa = '0; ab = '0; ash = '0;
        test_reset();
        test_alu();
        test_mul_div();
        test_decode();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
